ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, LED byte, 0xFF reset) from the FPGA to the keyboard over the shared open-collector PS2_CLK/PS2_DATA lines.
- Sits beside KeyboardDecoder.
- Top-level tri-state: each line is driven low when its `_oe` output is 1, and is Z otherwise.
- While this block is busy, `tx_busy` is used to gate the receiver.

Parameters:
- INHIBIT_CYC, 10000, clocks clk is held low before the start bit (100 us at 100 MHz).
- START_TO_CYC, 1500000, max clocks from clk release to the first device falling edge (15 ms).
- XFER_TO_CYC, 200000, max clocks from the first falling edge to ACK (2 ms).
- SYNC_STAGES, 2, synchroniser depth on ps2_clk_i and ps2_data_i.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- tx_data  in  8  byte to send, LSB first
- tx_valid  in  1  request; accepted when tx_valid & tx_ready
- tx_ready  out  1  high only in IDLE
- tx_busy  out  1  high in every state except IDLE
- tx_done  out  1  one-cycle pulse: ACK received and bus idle
- tx_err  out  1  one-cycle pulse: timeout or NACK
- ps2_clk_i  in  1  sampled PS2_CLK line
- ps2_data_i  in  1  sampled PS2_DATA line
- ps2_clk_oe  out  1  1 = pull PS2_CLK low
- ps2_data_oe  out  1  1 = pull PS2_DATA low

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, all counters cleared.
  - Outputs: tx_ready=1, tx_busy=0, tx_done=0, tx_err=0, ps2_clk_oe=0, ps2_data_oe=0.
  - Reset mid-frame releases both lines on the next cycle.
- Input synchronisation: both inputs pass through SYNC_STAGES FFs. `fall` = synced clk previous 1, current 0.
- Handshake:
  - On accept, latch tx_data and compute parity = ~^tx_data (odd).
  - Load the 11-bit frame {1 stop, parity, data[7:0], 0 start}.
  - tx_valid while busy is ignored, not queued.
- States:
  - IDLE: on accept -> INHIBIT.
  - INHIBIT: clk_oe=1 for INHIBIT_CYC cycles. On the last cycle, data_oe=1 (start bit). Then -> RELEASE.
  - RELEASE:
    - clk_oe=0, data_oe stays 1, bit_cnt=0, timer runs.
    - First `fall` -> shift the frame right by one; data_oe = ~frame[0] for data bit 0; -> DATA; timer restarts with the XFER limit.
    - Timer reaching START_TO_CYC -> ERR.
  - DATA:
    - On each `fall`, present the next bit: data_oe = ~bit. Order: D1..D7, parity, then the stop bit (data_oe=0).
    - After the 10th falling edge (stop presented) -> ACK.
  - ACK: on the next `fall`, sample synced data. 0 -> WAIT_IDLE; 1 -> ERR (NACK).
  - WAIT_IDLE: wait until synced clk=1 and data=1 -> DONE.
  - DONE: tx_done=1 for one cycle -> IDLE.
  - ERR: release both lines, tx_err=1 for one cycle -> IDLE.
- Timeouts: XFER_TO_CYC is counted from the first `fall` through WAIT_IDLE; expiry in any of these states -> ERR.
- Line drive: data_oe changes only in the cycle after a detected `fall`, i.e. while clk is low.
- Latency: accept -> clk released = INHIBIT_CYC+1 cycles.
- Timer width: $clog2(START_TO_CYC+1) bits, saturating.

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- Defined: a NACK or XFER timeout triggers one automatic retransmit of the latched byte (-> INHIBIT). tx_err pulses only if the retry also fails, and tx_done pulses once on success. START_TO timeout never retries.
- Undefined: every failure goes straight to ERR.

Decomposition:
- Shared package ps2_pkg:
  - State enum.
  - Command constants: CMD_SET_LED=8'hED, CMD_RESET=8'hFF, CMD_ECHO=8'hEE, ACK_BYTE=8'hFA.
  - LED bit positions: SCROLL=0, NUM=1, CAPS=2.
- Sub-module ps2_line_sync: synchroniser plus falling-edge detector, instanced once per line, reusable by the receiver.

Test Plan:
- Send 0xED, device model clocks at 12.5 kHz and ACKs:
  - Observed data bits are 1,0,1,1,0,1,1,1 and parity=1.
  - tx_done pulses once; tx_err stays 0; both oe=0 at the end.
- Send 0x04 (CAPS LED):
  - Parity=0.
  - clk_oe high for exactly INHIBIT_CYC cycles.
  - data_oe rises on the last inhibit cycle.
- Device never clocks, with START_TO_CYC=500 for sim: tx_err pulses 501 cycles after clk release; lines released.
- Device returns data=1 at the ACK edge:
  - Without the macro: tx_err.
  - With PS2_TX_RETRY_EN and a good second attempt: a second INHIBIT, then tx_done, no tx_err.
- Assert rst in DATA after bit 3: the next cycle shows IDLE, both oe=0, tx_ready=1; a new 0xFF then sends cleanly.
- Pulse tx_valid during a transfer with 0x55: the byte is ignored and the frame on the wire is unchanged.

Source files
------------

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host transmitter and its neighbours
// (KeyboardDecoder, receiver): transmitter state encoding, common keyboard
// command bytes, LED bit positions and the 11-bit frame builder.
// ---------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RELEASE,
        ST_DATA,
        ST_ACK,
        ST_WAIT_IDLE,
        ST_DONE,
        ST_ERR
    } ps2_tx_state_e;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ECHO    = 8'hEE;
    localparam logic [7:0] ACK_BYTE    = 8'hFA;

    // Bit positions inside the byte that follows CMD_SET_LED
    localparam int LED_SCROLL = 0;
    localparam int LED_NUM    = 1;
    localparam int LED_CAPS   = 2;

    localparam int FRAME_W = 11;

    // Frame as it leaves the host, LSB first: start(0), data, odd parity, stop(1)
    function automatic logic [FRAME_W-1:0] make_frame(input logic [7:0] data);
        return {1'b1, ~^data, data, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ---------------------------------------------------------------------------
// ps2_host_tx_if
// Byte-request handshake between a command source and ps2_host_tx.
//   tx_data  : byte to send (LSB first on the wire)
//   tx_valid : request, accepted when tx_valid & tx_ready
//   tx_ready : transmitter idle and able to accept
//   tx_busy  : transfer in progress (gates the PS/2 receiver)
//   tx_done  : one-cycle pulse, byte acknowledged and bus idle again
//   tx_err   : one-cycle pulse, timeout or NACK
// master = command source, slave = transmitter.
// ---------------------------------------------------------------------------
interface ps2_host_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_busy, tx_done, tx_err
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_busy, tx_done, tx_err
    );

endinterface

// File: rtl/ps2_line_sync.sv
// ---------------------------------------------------------------------------
// ps2_line_sync
// Brings one asynchronous PS/2 line into the clk domain and flags its
// falling edges. Used once per line; the receiver can reuse it as is.
//   clk, rst : system clock, synchronous active-high reset
//   line_i   : raw PS/2 line
//   line_o   : synchronised level
//   fall_o   : one-cycle pulse when line_o goes 1 -> 0
// ---------------------------------------------------------------------------
module ps2_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic line_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Lines idle high, so the chain resets to 1 to avoid a false edge
    // straight out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q[0] <= line_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign line_o = sync_q[SYNC_STAGES-1];
    assign fall_o = prev_q & ~line_o;

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter: sends one command byte to the keyboard
// over the shared open-collector PS2_CLK / PS2_DATA lines. The pad drives
// a line low while its _oe output is 1 and leaves it Z otherwise.
//
// Ports
//   clk, rst     : system clock, synchronous active-high reset
//   bus (slave)  : tx_data/tx_valid/tx_ready/tx_busy/tx_done/tx_err
//   ps2_clk_i    : PS2_CLK as seen on the pad
//   ps2_data_i   : PS2_DATA as seen on the pad
//   ps2_clk_oe   : 1 = pull PS2_CLK low
//   ps2_data_oe  : 1 = pull PS2_DATA low
//
// Build option
//   PS2_TX_RETRY_EN : when defined, a NACK or transfer timeout triggers one
//                     automatic resend of the latched byte; tx_err only
//                     pulses if that second attempt also fails. A start
//                     timeout (device never clocks) is never retried.
// ---------------------------------------------------------------------------
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYC  = 10000,
    parameter int unsigned START_TO_CYC = 1500000,
    parameter int unsigned XFER_TO_CYC  = 200000,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic               clk,
    input  logic               rst,
    ps2_host_tx_if.slave       bus,
    input  logic               ps2_clk_i,
    input  logic               ps2_data_i,
    output logic               ps2_clk_oe,
    output logic               ps2_data_oe
);

    // One timer serves inhibit, start and transfer timing, so it is sized
    // for the largest of the three limits.
    localparam int unsigned LIM_A     = (START_TO_CYC > XFER_TO_CYC) ? START_TO_CYC : XFER_TO_CYC;
    localparam int unsigned TIMER_MAX = (LIM_A > INHIBIT_CYC) ? LIM_A : INHIBIT_CYC;
    localparam int          TIMER_W   = $clog2(TIMER_MAX + 1);

    localparam logic [TIMER_W-1:0] INHIBIT_LAST = TIMER_W'(INHIBIT_CYC - 1);
    localparam logic [TIMER_W-1:0] START_LIMIT  = TIMER_W'(START_TO_CYC);
    localparam logic [TIMER_W-1:0] XFER_LIMIT   = TIMER_W'(XFER_TO_CYC);

    // Falling edges seen in DATA: D1..D7, parity, stop. The edge with
    // bit_cnt at this value presents the stop bit.
    localparam logic [3:0] STOP_EDGE = 4'd8;

    ps2_tx_state_e        state_q, state_n;
    logic [TIMER_W-1:0]   timer_q, timer_n, timer_inc;
    logic [FRAME_W-1:0]   frame_q, frame_n;
    logic [3:0]           bit_cnt_q, bit_cnt_n;
    logic                 xfer_fail;
    logic                 clk_oe_c, data_oe_c, done_c, err_c;

`ifdef PS2_TX_RETRY_EN
    logic [7:0]           byte_q, byte_n;
    logic                 retry_q, retry_n;
`endif

    logic                 clk_s, clk_fall;
    logic                 data_s, data_fall_unused;

    ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
        .clk    (clk),
        .rst    (rst),
        .line_i (ps2_clk_i),
        .line_o (clk_s),
        .fall_o (clk_fall)
    );

    ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_data_sync (
        .clk    (clk),
        .rst    (rst),
        .line_i (ps2_data_i),
        .line_o (data_s),
        .fall_o (data_fall_unused)
    );

    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;

    // Next-state and output decode. data_oe only ever changes on the cycle
    // after a detected falling edge (device clock low), apart from the start
    // bit which is asserted while the host itself holds the clock low.
    always_comb begin
        state_n   = state_q;
        timer_n   = timer_inc;
        frame_n   = frame_q;
        bit_cnt_n = bit_cnt_q;
        xfer_fail = 1'b0;
        clk_oe_c  = 1'b0;
        data_oe_c = 1'b0;
        done_c    = 1'b0;
        err_c     = 1'b0;
`ifdef PS2_TX_RETRY_EN
        byte_n    = byte_q;
        retry_n   = retry_q;
`endif

        case (state_q)
            ST_IDLE: begin
                timer_n = '0;
                if (bus.tx_valid) begin
                    frame_n = make_frame(bus.tx_data);
                    state_n = ST_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    byte_n  = bus.tx_data;
                    retry_n = 1'b0;
`endif
                end
            end

            ST_INHIBIT: begin
                clk_oe_c = 1'b1;
                if (timer_q == INHIBIT_LAST) begin
                    data_oe_c = 1'b1;
                    state_n   = ST_RELEASE;
                    timer_n   = '0;
                    bit_cnt_n = '0;
                end
            end

            // Start bit stays on the line until the device's first edge,
            // which also starts the transfer timeout.
            ST_RELEASE: begin
                data_oe_c = 1'b1;
                if (clk_fall) begin
                    frame_n = {1'b1, frame_q[FRAME_W-1:1]};
                    state_n = ST_DATA;
                    timer_n = '0;
                end else if (timer_q == START_LIMIT) begin
                    state_n = ST_ERR;
                    timer_n = '0;
                end
            end

            ST_DATA: begin
                data_oe_c = ~frame_q[0];
                if (timer_q == XFER_LIMIT) begin
                    xfer_fail = 1'b1;
                end else if (clk_fall) begin
                    frame_n   = {1'b1, frame_q[FRAME_W-1:1]};
                    bit_cnt_n = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == STOP_EDGE) begin
                        state_n = ST_ACK;
                    end
                end
            end

            // Device pulls data low on the next edge to acknowledge.
            ST_ACK: begin
                if (timer_q == XFER_LIMIT) begin
                    xfer_fail = 1'b1;
                end else if (clk_fall) begin
                    if (data_s) begin
                        xfer_fail = 1'b1;
                    end else begin
                        state_n = ST_WAIT_IDLE;
                    end
                end
            end

            ST_WAIT_IDLE: begin
                if (timer_q == XFER_LIMIT) begin
                    xfer_fail = 1'b1;
                end else if (clk_s && data_s) begin
                    state_n = ST_DONE;
                    timer_n = '0;
                end
            end

            ST_DONE: begin
                done_c  = 1'b1;
                state_n = ST_IDLE;
                timer_n = '0;
            end

            ST_ERR: begin
                err_c   = 1'b1;
                state_n = ST_IDLE;
                timer_n = '0;
            end

            default: begin
                state_n = ST_IDLE;
                timer_n = '0;
            end
        endcase

        // A failed transfer either gets its single resend or ends in ERR.
        if (xfer_fail) begin
            timer_n = '0;
`ifdef PS2_TX_RETRY_EN
            if (!retry_q) begin
                state_n = ST_INHIBIT;
                retry_n = 1'b1;
                frame_n = make_frame(byte_q);
            end else begin
                state_n = ST_ERR;
            end
`else
            state_n = ST_ERR;
`endif
        end
    end

    // State register; reset anywhere in a frame releases both lines on the
    // following cycle because all drives decode from IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            frame_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_n;
            timer_q   <= timer_n;
            frame_q   <= frame_n;
            bit_cnt_q <= bit_cnt_n;
        end
    end

`ifdef PS2_TX_RETRY_EN
    // Byte and retry flag kept for the one automatic resend.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_q  <= '0;
            retry_q <= 1'b0;
        end else begin
            byte_q  <= byte_n;
            retry_q <= retry_n;
        end
    end
`endif

    assign bus.tx_ready = (state_q == ST_IDLE);
    assign bus.tx_busy  = (state_q != ST_IDLE);
    assign bus.tx_done  = done_c;
    assign bus.tx_err   = err_c;
    assign ps2_clk_oe   = clk_oe_c;
    assign ps2_data_oe  = data_oe_c;

endmodule
